// File: rtl/cpu_control_unit.sv
// Main decoder for the MiniMicro datapath: decodes the opcode (plus ALU flags for the
// conditional moves) into registered control strobes with one cycle of latency.
module cpu_control_unit #(
    parameter int unsigned word_size   = 32,
    parameter int unsigned opcode_size = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [word_size-1:0]   instruction,
    input  logic [3:0]             flags,
    output logic                   mem_to_reg,
    output logic                   mem_write,
    output logic                   reg_write,
    output logic [opcode_size-1:0] alu_ctrl,
    output logic                   alu_src,
    output logic                   imm_src
);

    localparam logic [opcode_size-1:0] OpNop   = opcode_size'(5'b00000);
    localparam logic [opcode_size-1:0] OpRegLo = opcode_size'(5'b00001);
    localparam logic [opcode_size-1:0] OpRegHi = opcode_size'(5'b01111);
    localparam logic [opcode_size-1:0] OpAddi  = opcode_size'(5'b10000);
    localparam logic [opcode_size-1:0] OpSubi  = opcode_size'(5'b10001);
    localparam logic [opcode_size-1:0] OpCmp   = opcode_size'(5'b10010);
    localparam logic [opcode_size-1:0] OpLoad  = opcode_size'(5'b10011);
    localparam logic [opcode_size-1:0] OpStore = opcode_size'(5'b10100);
    localparam logic [opcode_size-1:0] OpMovz  = opcode_size'(5'b11000);
    localparam logic [opcode_size-1:0] OpMovnz = opcode_size'(5'b11001);
    localparam logic [opcode_size-1:0] OpMovn  = opcode_size'(5'b11010);
    localparam logic [opcode_size-1:0] OpMovc  = opcode_size'(5'b11011);

    localparam logic [opcode_size-1:0] AluPassB = opcode_size'(5'b00000);
    localparam logic [opcode_size-1:0] AluAdd   = opcode_size'(5'b00110);
    localparam logic [opcode_size-1:0] AluSub   = opcode_size'(5'b00111);

    logic [opcode_size-1:0] op;
    logic                   flag_n, flag_z, flag_c;

    assign op     = instruction[word_size-1 -: opcode_size];
    assign flag_n = flags[3];
    assign flag_z = flags[2];
    assign flag_c = flags[1];

    // Operand fields and the V flag are routed by the datapath, not decoded here.
    logic unused_fields;
    assign unused_fields = ^{instruction[word_size-opcode_size-1:0], flags[0]};

    logic                   mem_to_reg_d, mem_write_d, reg_write_d, alu_src_d, imm_src_d;
    logic [opcode_size-1:0] alu_ctrl_d;
    logic                   mov_cond;

    always_comb begin
        mem_to_reg_d = 1'b0;
        mem_write_d  = 1'b0;
        reg_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        imm_src_d    = 1'b0;
        alu_ctrl_d   = AluPassB;
        mov_cond     = 1'b0;
        case (op) inside
            OpNop: ;
            [OpRegLo:OpRegHi]: begin
                reg_write_d = 1'b1;
                alu_ctrl_d  = op;
            end
            OpAddi, OpSubi: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                imm_src_d   = 1'b1;
                alu_ctrl_d  = (op == OpAddi) ? AluAdd : AluSub;
            end
            OpCmp: alu_ctrl_d = AluSub;
            OpLoad: begin
                mem_to_reg_d = 1'b1;
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                alu_ctrl_d   = AluAdd;
            end
            OpStore: begin
                mem_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_ctrl_d  = AluAdd;
            end
            OpMovz, OpMovnz, OpMovn, OpMovc: begin
                case (op)
                    OpMovz:  mov_cond = flag_z;
                    OpMovnz: mov_cond = !flag_z;
                    OpMovn:  mov_cond = flag_n;
                    default: mov_cond = flag_c;
                endcase
                // A failed condition decodes as NOP; pass-B with alu_src=0 is all-zero anyway.
                reg_write_d = mov_cond;
            end
            // Reserved opcodes and unknown bits fall through to NOP.
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_to_reg <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= 1'b0;
            alu_ctrl   <= '0;
            alu_src    <= 1'b0;
            imm_src    <= 1'b0;
        end else begin
            mem_to_reg <= mem_to_reg_d;
            mem_write  <= mem_write_d;
            reg_write  <= reg_write_d;
            alu_ctrl   <= alu_ctrl_d;
            alu_src    <= alu_src_d;
            imm_src    <= imm_src_d;
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed cases plus randomized instructions,
// flags and asynchronous resets compared against a table-driven reference model.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic [3:0]  flags;
    logic        mem_to_reg, mem_write, reg_write, alu_src, imm_src;
    logic [4:0]  alu_ctrl;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q;
    logic [9:0] dut_out;

    cpu_control_unit #(
        .word_size   (32),
        .opcode_size (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .flags       (flags),
        .mem_to_reg  (mem_to_reg),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .alu_ctrl    (alu_ctrl),
        .alu_src     (alu_src),
        .imm_src     (imm_src)
    );

    always #5 clk = ~clk;

    // Packed as {mem_to_reg, mem_write, reg_write, alu_ctrl[4:0], alu_src, imm_src}.
    assign dut_out = {mem_to_reg, mem_write, reg_write, alu_ctrl, alu_src, imm_src};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ref_model(input logic [31:0] ins, input logic [3:0] fl);
        int op;
        bit m2r, mw, rw, as, is, cond;
        int ac;
        op = int'(ins[31:27]);
        m2r = 0; mw = 0; rw = 0; as = 0; is = 0; ac = 0; cond = 0;
        if (op >= 1 && op <= 15) begin
            rw = 1; ac = op;
        end else if (op == 16 || op == 17) begin
            rw = 1; as = 1; is = 1; ac = (op == 16) ? 6 : 7;
        end else if (op == 18) begin
            ac = 7;
        end else if (op == 19) begin
            m2r = 1; rw = 1; as = 1; ac = 6;
        end else if (op == 20) begin
            mw = 1; as = 1; ac = 6;
        end else if (op >= 24 && op <= 27) begin
            case (op)
                24:      cond = fl[2];
                25:      cond = !fl[2];
                26:      cond = fl[3];
                default: cond = fl[1];
            endcase
            rw = cond;
        end
        return {m2r, mw, rw, 5'(ac), as, is};
    endfunction

    task automatic check_invariants(input string tag);
        check_eq({tag, " mw&rw"}, 32'(mem_write & reg_write), 32'd0);
        check_eq({tag, " m2r!rw"}, 32'(mem_to_reg & ~reg_write), 32'd0);
    endtask

    // Called just after a rising edge; outputs must hold until the next edge.
    task automatic apply(input logic [31:0] ins, input logic [3:0] fl, input string tag);
        instruction = ins;
        flags       = fl;
        #1;
        check_eq({tag, " hold"}, 32'(dut_out), 32'(exp_q));
        @(posedge clk);
        exp_q = ref_model(ins, fl);
        #1;
        check_eq(tag, 32'(dut_out), 32'(exp_q));
        check_invariants(tag);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b0;
        #1;
        exp_q = '0;
        check_eq({tag, " async"}, 32'(dut_out), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check_eq({tag, " post"}, 32'(dut_out), 32'd0);
    endtask

    initial begin
        logic [31:0] ins;
        int          op;
        rst         = 1'b0;
        instruction = 32'h9800_0200;
        flags       = 4'b0000;
        exp_q       = '0;
        #2;
        check_eq("reset async", 32'(dut_out), 32'd0);
        @(posedge clk);
        #1;
        check_eq("reset held over edge", 32'(dut_out), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("reset released pre-edge", 32'(dut_out), 32'd0);
        @(posedge clk);
        exp_q = ref_model(instruction, flags);
        #1;
        check_eq("load0", 32'(dut_out), 32'(10'b1_0_1_00110_1_0));

        apply(32'h9804_0201, 4'b0000, "load1");
        check_eq("load1 table", 32'(dut_out), 32'(10'b1_0_1_00110_1_0));
        apply(32'h3000_0202, 4'b0000, "add");
        check_eq("add table", 32'(dut_out), 32'(10'b0_0_1_00110_0_0));
        apply(32'hA000_0000, 4'b0000, "store");
        check_eq("store table", 32'(dut_out), 32'(10'b0_1_0_00110_1_0));
        apply(32'h0000_0000, 4'b0000, "nop");
        check_eq("nop table", 32'(dut_out), 32'd0);
        apply(32'hC000_0000, 4'b0100, "movz taken");
        check_eq("movz taken table", 32'(dut_out), 32'(10'b0_0_1_00000_0_0));
        apply(32'hC000_0000, 4'b0000, "movz not");
        check_eq("movz not table", 32'(dut_out), 32'd0);
        apply(32'hD800_0000, 4'b0010, "movc taken");
        check_eq("movc taken table", 32'(dut_out), 32'(10'b0_0_1_00000_0_0));
        apply(32'hF800_0000, 4'b1111, "reserved");
        check_eq("reserved table", 32'(dut_out), 32'd0);
        apply(32'h8000_0000, 4'b0000, "addi");
        check_eq("addi table", 32'(dut_out), 32'(10'b0_0_1_00110_1_1));
        apply(32'h9000_0000, 4'b0000, "cmp");
        check_eq("cmp table", 32'(dut_out), 32'(10'b0_0_0_00111_0_0));
        pulse_reset("midreset");

        for (int i = 0; i < 400; i++) begin
            op  = int'($urandom_range(0, 31));
            ins = {5'(op), 27'($urandom)};
            apply(ins, 4'($urandom), $sformatf("rnd%0d op%0d", i, op));
            if ($urandom_range(0, 39) == 0) pulse_reset($sformatf("rnd%0d reset", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
